// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned MULTU/DIVU unit that owns HI/LO.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : ToLH strobe, current instruction is MULTU or DIVU
//   is_div : 1 = DIVU, 0 = MULTU (sampled on accept only)
//   op_a   : multiplicand / dividend
//   op_b   : multiplier / divisor
//   stall  : hold PC and suppress writes of the current instruction
//   busy   : iteration in progress
//   done   : one-cycle pulse, HI/LO hold the new result
//   hi, lo : HI/LO registers (product halves, or remainder/quotient)
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  // a_r: multiplicand (MULTU) or divisor (DIVU).
  logic [WIDTH-1:0]   a_r, a_s;
  // sh_r: multiplier shifting out while product low bits shift in (MULTU),
  // or dividend shifting out while quotient bits shift in (DIVU).
  logic [WIDTH-1:0]   sh_r, sh_s;
  // acc_r: upper product half (MULTU) or partial remainder (DIVU).
  logic [WIDTH-1:0]   acc_r, acc_s;
  logic [WIDTH-1:0]   hi_r, hi_s;
  logic [WIDTH-1:0]   lo_r, lo_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     rem_s;
  logic [WIDTH:0]     trial_s;
  logic               last_s;

  assign last_s = (cnt_r == CNT_W'(WIDTH - 1));
  assign busy   = (state_r == S_MUL) || (state_r == S_DIV);
  assign done   = (state_r == S_DONE);
  // The accept cycle must stall too, before busy is registered.
  assign stall  = ((state_r == S_IDLE) && start) || busy;
  assign hi     = hi_r;
  assign lo     = lo_r;

  // Next-state and datapath iteration logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    a_s     = a_r;
    sh_s    = sh_r;
    acc_s   = acc_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    sum_s   = '0;
    rem_s   = '0;
    trial_s = '0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          a_s     = is_div ? op_b : op_a;
          sh_s    = is_div ? op_a : op_b;
          acc_s   = '0;
          cnt_s   = '0;
          state_s = is_div ? S_DIV : S_MUL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL: begin
        // Add with carry kept, then shift {carry, acc, sh} right by one.
        sum_s = {1'b0, acc_r} + (sh_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        acc_s = sum_s[WIDTH:1];
        sh_s  = {sum_s[0], sh_r[WIDTH-1:1]};
        cnt_s = cnt_r + CNT_W'(1);
        if (last_s) begin
          state_s = S_DONE;
          hi_s    = sum_s[WIDTH:1];
          lo_s    = {sum_s[0], sh_r[WIDTH-1:1]};
        end else begin
          state_s = S_MUL;
        end
      end
      S_DIV: begin
        rem_s   = {acc_r, sh_r[WIDTH-1]};
        trial_s = rem_s - {1'b0, a_r};
        // Non-negative trial: accept subtraction and set quotient bit.
        if (!trial_s[WIDTH]) begin
          acc_s = trial_s[WIDTH-1:0];
          sh_s  = {sh_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_s = rem_s[WIDTH-1:0];
          sh_s  = {sh_r[WIDTH-2:0], 1'b0};
        end
        cnt_s = cnt_r + CNT_W'(1);
        if (last_s) begin
          state_s = S_DONE;
          hi_s    = acc_s;
          lo_s    = sh_s;
        end else begin
          state_s = S_DIV;
        end
      end
      S_DONE: begin
        // start is still high for the retiring instruction; ignore it.
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and HI/LO registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      a_r   <= '0;
      sh_r  <= '0;
      acc_r <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      cnt_r <= cnt_s;
      a_r   <= a_s;
      sh_r  <= sh_s;
      acc_r <= acc_s;
      hi_r  <= hi_s;
      lo_r  <= lo_s;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vec_cnt = 0;
  int miss_cnt = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (is_div),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever the unit presents a result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h with no pending op", hi, lo);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
      end
    end
  end

  // Issue one op (called just after a rising edge, unit in IDLE) and
  // follow it to DONE; returns just after the edge that leaves DONE.
  task automatic run_op(input string nm, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit churn);
    logic [63:0] prev;
    int cyc;
    int stl;
    bit got;
    prev   = {hi, lo};
    start  = 1'b1;
    is_div = d;
    op_a   = a;
    op_b   = b;
    sb_q.push_back('{exp_hi, exp_lo, nm});
    #1 check({nm, "_accept_stall"}, {63'd0, stall}, 64'd1);
    cyc = 0;
    stl = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (stall) stl++;
      if (done) begin
        got = 1'b1;
      end else begin
        check({nm, "_hilo_hold"}, {hi, lo}, prev);
        if (churn && cyc > 1) begin
          op_a   = $urandom;
          op_b   = $urandom;
          is_div = 1'($urandom_range(0, 1));
        end
      end
    end
    check({nm, "_done_cycle"}, 64'(cyc), 64'd34);
    check({nm, "_stall_cycles"}, 64'(stl), 64'd33);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    is_div = 1'b0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {59'd0, stall, busy, done, 2'b00}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("mul_7x6",      1'b0, 32'd7,          32'd6,          32'h00000000, 32'h0000002A, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    run_op("mul_max",      1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mul_msb_x2",   1'b0, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000, 1'b0);
    run_op("div_100_7",    1'b1, 32'd100,        32'd7,          32'd2,        32'd14,       1'b0);
    run_op("div_max_16",   1'b1, 32'hFFFFFFFF,   32'h10,         32'h0000000F, 32'h0FFFFFFF, 1'b0);
    run_op("div_5_9",      1'b1, 32'd5,          32'd9,          32'd5,        32'd0,        1'b0);
    run_op("div_by_zero",  1'b1, 32'h12345678,   32'd0,          32'h12345678, 32'hFFFFFFFF, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", {hi, lo}, {32'h12345678, 32'hFFFFFFFF});

    // Abort a MULTU 3x3 with reset during iteration 10.
    start  = 1'b1;
    is_div = 1'b0;
    op_a   = 32'd3;
    op_b   = 32'd3;
    repeat (11) @(negedge clk);
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("abort_stall", {62'd0, stall, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("div_9_2",      1'b1, 32'd9,          32'd2,          32'd1,        32'd4,        1'b0);
    start = 1'b0;
    @(posedge clk); #1;

    // Back-to-back with operand churn during the first op.
    run_op("mul_5x5_churn", 1'b0, 32'd5,         32'd5,          32'd0,        32'd25,       1'b1);
    run_op("div_25_4_b2b",  1'b1, 32'd25,        32'd4,          32'd1,        32'd6,        1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle_hold", {hi, lo}, {32'd1, 32'd6});
    check("final_idle_stall", {62'd0, stall, busy}, 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
